// File: rtl/midi_pkg.sv
// midi_pkg: MIDI constants, bit-timing and status-to-length helpers shared by the tx and rx paths.
package midi_pkg;
   localparam logic [3:0] CMD_NOTE_OFF = 4'h8;
   localparam logic [3:0] CMD_NOTE_ON  = 4'h9;
   localparam logic [3:0] CMD_POLY_AT  = 4'hA;
   localparam logic [3:0] CMD_CTRL     = 4'hB;
   localparam logic [3:0] CMD_PROG     = 4'hC;
   localparam logic [3:0] CMD_CHAN_AT  = 4'hD;
   localparam logic [3:0] CMD_PITCH    = 4'hE;
   localparam logic [3:0] CMD_SYS      = 4'hF;
   localparam logic [7:0] RT_MIN       = 8'hF8;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} tx_state_t;

   function automatic int clks_per_bit(input int clk_f, input int baud);
      return clk_f / baud;
   endfunction

   // Total bytes on the wire for a status byte; 0 flags a non-status byte.
   function automatic logic [1:0] msg_len(input logic [7:0] s);
      if (!s[7]) return 2'd0;
      case (s[7:4])
         CMD_PROG, CMD_CHAN_AT: return 2'd2;
         CMD_SYS: return (s == 8'hF1 || s == 8'hF3) ? 2'd2 : (s == 8'hF2) ? 2'd3 : 2'd1;
         default: return 2'd3;
      endcase
   endfunction
endpackage

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: 8N1 byte serialiser driving the MIDI OUT line, LSB first.
module midi_uart_tx #(
   parameter int CLKS_PER_BIT = 1536
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_done,
   output logic       MIDI_DOUT
);
   logic [10:0] baud_cnt;
   logic [3:0]  bit_idx;
   logic [8:0]  shreg;
   logic        active;
   logic        bit_end;

   assign bit_end = active && baud_cnt == 11'(CLKS_PER_BIT - 1);
   // Done fires in the last stop-bit cycle so the caller's LOAD cycle is the only inter-byte gap.
   assign tx_done = bit_end && bit_idx == 4'd9;

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         active    <= 1'b0;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= '1;
         MIDI_DOUT <= 1'b1;
      end else if (tx_start && !active) begin
         active    <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= {1'b1, tx_byte};
         MIDI_DOUT <= 1'b0;
      end else if (bit_end) begin
         baud_cnt  <= '0;
         bit_idx   <= bit_idx + 4'd1;
         active    <= bit_idx != 4'd9;
         MIDI_DOUT <= tx_done ? 1'b1 : shreg[0];
         shreg     <= {1'b1, shreg[8:1]};
      end else if (active) begin
         baud_cnt  <= baud_cnt + 11'd1;
      end
   end
endmodule

// File: rtl/midi_message_tx.sv
// midi_message_tx: serialises complete MIDI messages with running status and real-time byte injection.
module midi_message_tx
   import midi_pkg::*;
#(
   parameter int SYS_CLK_F      = 48000000,
   parameter int MIDI_BAUD      = 31250,
   parameter int BYTE_W         = 8,
   parameter int RUNNING_STATUS = 1
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              msg_valid,
   output logic              msg_ready,
   input  logic [BYTE_W-1:0] msg_status,
   input  logic [BYTE_W-1:0] msg_data0,
   input  logic [BYTE_W-1:0] msg_data1,
   input  logic              rt_valid,
   output logic              rt_ready,
   input  logic [BYTE_W-1:0] rt_byte,
   output logic              msg_error,
   output logic              busy,
   output logic              MIDI_DOUT
);
   localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK_F, MIDI_BAUD);
   localparam logic [BYTE_W-1:0] DATA_MASK = {1'b0, {(BYTE_W-1){1'b1}}};

   tx_state_t         st, st_nx;
   logic [BYTE_W-1:0] status_q, d0_q, d1_q, rt_q, last_status, data_sel, tx_byte;
   logic [1:0]        cur, len;
   logic              rt_pend, tx_done, tx_start, msg_acc, rt_acc, msg_bad, rt_bad, more, skip;

   assign msg_ready = st == ST_IDLE;
   assign rt_ready  = !rt_pend;
   assign busy      = st != ST_IDLE || rt_pend;
   assign msg_acc   = msg_valid && msg_ready;
   assign rt_acc    = rt_valid && rt_ready;
   assign msg_bad   = !msg_status[BYTE_W-1];
   assign rt_bad    = rt_byte < RT_MIN;
   assign more      = rt_pend || cur != len;
   assign skip      = RUNNING_STATUS != 0 && msg_status[7:4] != CMD_SYS && msg_status == last_status;
   assign tx_start  = st == ST_LOAD;
   assign data_sel  = cur == 2'd1 ? d0_q : d1_q;
   // A pending real-time byte always wins the next LOAD slot.
   assign tx_byte   = rt_pend ? rt_q : cur == 2'd0 ? status_q : data_sel & DATA_MASK;

   always_comb begin
      st_nx = st;
      case (st)
         ST_IDLE: st_nx = (msg_acc && !msg_bad) || rt_pend ? ST_LOAD : ST_IDLE;
         ST_LOAD: st_nx = ST_SEND;
         ST_SEND: st_nx = !tx_done ? ST_SEND : more ? ST_LOAD : ST_DONE;
         default: st_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         st          <= ST_IDLE;
         rt_pend     <= 1'b0;
         msg_error   <= 1'b0;
         last_status <= '0;
         cur         <= '0;
         len         <= '0;
         status_q    <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         rt_q        <= '0;
      end else begin
         st        <= st_nx;
         msg_error <= (msg_acc && msg_bad) || (rt_acc && rt_bad);
         if (msg_acc && !msg_bad) begin
            status_q <= msg_status;
            d0_q     <= msg_data0;
            d1_q     <= msg_data1;
            len      <= msg_len(msg_status);
            cur      <= skip ? 2'd1 : 2'd0;
            if (msg_status[7:4] != CMD_SYS) last_status <= msg_status;
            else if (msg_status < RT_MIN) last_status <= '0;
         end
         if (st == ST_LOAD) begin
            if (rt_pend) rt_pend <= 1'b0;
            else cur <= cur + 2'd1;
         end
         if (rt_acc && !rt_bad) begin
            rt_pend <= 1'b1;
            rt_q    <= rt_byte;
         end
      end
   end

   midi_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .tx_start  (tx_start),
      .tx_byte   (tx_byte),
      .tx_done   (tx_done),
      .MIDI_DOUT (MIDI_DOUT)
   );
endmodule
